// File: rtl/sram_march_bist_if.sv
// Port group between the March C- BIST controller and the SRAM BIST port,
// plus the start/status signals seen by the test host.
//   master : controller side (drives the SRAM BIST port and status)
//   slave  : SRAM/host side (drives A_START and A_BIST_DOUT)
// Optional macro SRAM_MARCH_BIST_FAIL_CNT_EN adds the A_FAIL_CNT status field.
interface sram_march_bist_if #(
  parameter int unsigned P_DATA_WIDTH = 64,
  parameter int unsigned P_ADDR_WIDTH = 6
);
  logic                    A_START;
  logic                    A_BIST_EN;
  logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR;
  logic [P_DATA_WIDTH-1:0] A_BIST_DIN;
  logic [P_DATA_WIDTH-1:0] A_BIST_BM;
  logic                    A_BIST_MEN;
  logic                    A_BIST_WEN;
  logic                    A_BIST_REN;
  logic [P_DATA_WIDTH-1:0] A_BIST_DOUT;
  logic                    A_BUSY;
  logic                    A_DONE;
  logic                    A_FAIL;
  logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR;
  logic [2:0]              A_FAIL_ELEM;
`ifdef SRAM_MARCH_BIST_FAIL_CNT_EN
  logic [15:0]             A_FAIL_CNT;

  modport master (
    input  A_START, A_BIST_DOUT,
    output A_BIST_EN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM, A_BIST_MEN, A_BIST_WEN,
           A_BIST_REN, A_BUSY, A_DONE, A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM, A_FAIL_CNT
  );
  modport slave (
    output A_START, A_BIST_DOUT,
    input  A_BIST_EN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM, A_BIST_MEN, A_BIST_WEN,
           A_BIST_REN, A_BUSY, A_DONE, A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM, A_FAIL_CNT
  );
`else
  modport master (
    input  A_START, A_BIST_DOUT,
    output A_BIST_EN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM, A_BIST_MEN, A_BIST_WEN,
           A_BIST_REN, A_BUSY, A_DONE, A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM
  );
  modport slave (
    output A_START, A_BIST_DOUT,
    input  A_BIST_EN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM, A_BIST_MEN, A_BIST_WEN,
           A_BIST_REN, A_BUSY, A_DONE, A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM
  );
`endif
endinterface

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST controller for a single-port SRAM macro.
// Runs E0 up(w0), E1 up(r0,w1), E2 up(r1,w0), E3 down(r0,w1), E4 down(r1,w0),
// E5 up(r0): one SRAM op per cycle (10N ops), one drain cycle for the last
// read compare, then DONE with pass/fail and first-failure address/element.
// Ports:
//   A_CLK    : clock (also the SRAM BIST clock)
//   A_RST_N  : synchronous active-low reset
//   bus      : sram_march_bist_if.master (SRAM BIST port group, start, status)
// Optional macro SRAM_MARCH_BIST_FAIL_CNT_EN adds a saturating 16-bit
// mismatch counter on bus.A_FAIL_CNT.
module sram_march_bist_ctrl #(
  parameter int unsigned P_DATA_WIDTH = 64,
  parameter int unsigned P_ADDR_WIDTH = 6
) (
  input logic               A_CLK,
  input logic               A_RST_N,
  sram_march_bist_if.master bus
);

  localparam int unsigned DW = P_DATA_WIDTH;
  localparam int unsigned AW = P_ADDR_WIDTH;
  localparam logic [AW-1:0] ADDR_MAX = '1;
  localparam logic [DW-1:0] ONES     = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      elem_q, elem_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            phase_q, phase_d;      // 0: read slot, 1: write slot of r/w element

  logic            bist_en_q, bist_en_d;
  logic [AW-1:0]   bist_addr_q, bist_addr_d;
  logic [DW-1:0]   bist_din_q, bist_din_d;
  logic [DW-1:0]   bist_bm_q, bist_bm_d;
  logic            men_q, men_d;
  logic            wen_q, wen_d;
  logic            ren_q, ren_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            cmp_vld_q, cmp_vld_d;
  logic [DW-1:0]   cmp_exp_q, cmp_exp_d;
  logic [AW-1:0]   cmp_addr_q, cmp_addr_d;
  logic [2:0]      cmp_elem_q, cmp_elem_d;

  logic            fail_q, fail_d;
  logic [AW-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]      fail_elem_q, fail_elem_d;

  logic            start_c;
  logic            mismatch_c;
  logic            elem_rw_c, elem_down_c, elem_last_c;
  logic [2:0]      elem_nxt_c;
  logic            run_c, rd_c;

  // Element attributes of the op currently on the SRAM port
  always_comb begin
    elem_rw_c   = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    elem_down_c = (elem_q == 3'd3) || (elem_q == 3'd4);
    elem_last_c = elem_down_c ? (addr_q == '0) : (addr_q == ADDR_MAX);
    elem_nxt_c  = elem_q + 3'd1;
    mismatch_c  = cmp_vld_q && (bus.A_BIST_DOUT != cmp_exp_q);
  end

  // Next state, march sequencing, registered outputs and compare pipeline
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    start_c     = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.A_START) begin
          state_d = S_RUN;
          elem_d  = 3'd0;
          addr_d  = '0;
          phase_d = 1'b0;
          done_d  = 1'b0;
          start_c = 1'b1;
        end
      end
      S_RUN: begin
        if (elem_rw_c && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (elem_last_c) begin
            if (elem_q == 3'd5) begin
              state_d = S_DRAIN;
            end else begin
              elem_d = elem_nxt_c;
              addr_d = ((elem_nxt_c == 3'd3) || (elem_nxt_c == 3'd4)) ? ADDR_MAX : '0;
            end
          end else begin
            addr_d = elem_down_c ? (addr_q - AW'(1)) : (addr_q + AW'(1));
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // First mismatch wins the diagnostics; the flag stays sticky
    if (mismatch_c) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
      end
    end
    if (start_c) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = 3'd0;
    end

    // Output registers carry the op selected by the next counter values
    run_c       = (state_d == S_RUN);
    rd_c        = run_c && ((elem_d == 3'd5) ||
                            ((elem_d >= 3'd1) && (elem_d <= 3'd4) && !phase_d));
    bist_en_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
    busy_d      = bist_en_d;
    bist_bm_d   = bist_en_d ? ONES : '0;
    men_d       = run_c;
    ren_d       = rd_c;
    wen_d       = run_c && !rd_c;
    bist_addr_d = run_c ? addr_d : '0;
    bist_din_d  = (wen_d && ((elem_d == 3'd1) || (elem_d == 3'd3))) ? ONES : '0;

    // Expected word for the read on the port now; compared next cycle
    cmp_vld_d   = ren_q;
    cmp_exp_d   = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ONES : '0;
    cmp_addr_d  = addr_q;
    cmp_elem_d  = elem_q;
  end

  always_ff @(posedge A_CLK) begin
    if (!A_RST_N) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      bist_en_q   <= 1'b0;
      bist_addr_q <= '0;
      bist_din_q  <= '0;
      bist_bm_q   <= '0;
      men_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= 3'd0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      bist_en_q   <= bist_en_d;
      bist_addr_q <= bist_addr_d;
      bist_din_q  <= bist_din_d;
      bist_bm_q   <= bist_bm_d;
      men_q       <= men_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  assign bus.A_BIST_EN   = bist_en_q;
  assign bus.A_BIST_ADDR = bist_addr_q;
  assign bus.A_BIST_DIN  = bist_din_q;
  assign bus.A_BIST_BM   = bist_bm_q;
  assign bus.A_BIST_MEN  = men_q;
  assign bus.A_BIST_WEN  = wen_q;
  assign bus.A_BIST_REN  = ren_q;
  assign bus.A_BUSY      = busy_q;
  assign bus.A_DONE      = done_q;
  assign bus.A_FAIL      = fail_q;
  assign bus.A_FAIL_ADDR = fail_addr_q;
  assign bus.A_FAIL_ELEM = fail_elem_q;

`ifdef SRAM_MARCH_BIST_FAIL_CNT_EN
  logic [15:0] fail_cnt_q, fail_cnt_d;

  // Saturating count of every mismatching read compare
  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (mismatch_c && (fail_cnt_q != 16'hFFFF)) begin
      fail_cnt_d = fail_cnt_q + 16'd1;
    end
    if (start_c) begin
      fail_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge A_CLK) begin
    if (!A_RST_N) begin
      fail_cnt_q <= 16'd0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign bus.A_FAIL_CNT = fail_cnt_q;
`endif

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Bench for sram_march_bist_ctrl with a 4x8 behavioural SRAM carrying
// configurable stuck-at faults and an abstract March C- reference model.
module tb_sram_march_bist_ctrl;

  localparam int unsigned AW  = 2;
  localparam int unsigned DW  = 8;
  localparam int          N   = 4;
  localparam int          OPS = 10 * N;

  logic clk;
  logic rst_n;

  sram_march_bist_if #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) bus ();

  sram_march_bist_ctrl #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
    .A_CLK   (clk),
    .A_RST_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural SRAM with per-address stuck-at masks applied on write
  logic [DW-1:0] mem [N];
  logic [DW-1:0] sa1 [N];
  logic [DW-1:0] sa0 [N];

  always @(posedge clk) begin
    if (bus.A_BIST_EN && bus.A_BIST_MEN && bus.A_BIST_WEN)
      mem[bus.A_BIST_ADDR] <= (bus.A_BIST_DIN | sa1[bus.A_BIST_ADDR]) & ~sa0[bus.A_BIST_ADDR];
    if (bus.A_BIST_EN && bus.A_BIST_MEN && bus.A_BIST_REN)
      bus.A_BIST_DOUT <= mem[bus.A_BIST_ADDR];
  end

  // Expected op stream and expected diagnostics from the march definition
  logic          exp_rd   [OPS];
  int            exp_addr [OPS];
  logic [DW-1:0] exp_din  [OPS];
  logic          exp_fail;
  int            exp_fail_addr, exp_fail_elem, exp_cnt;

  task automatic build_ops();
    int k = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        int a = (e == 3 || e == 4) ? N - 1 - i : i;
        if (e != 0) begin
          exp_rd[k] = 1'b1; exp_addr[k] = a; exp_din[k] = '0; k++;
        end
        if (e != 5) begin
          exp_rd[k] = 1'b0; exp_addr[k] = a;
          exp_din[k] = (e == 1 || e == 3) ? 8'hFF : 8'h00; k++;
        end
      end
    end
  endtask

  task automatic model_march();
    logic [DW-1:0] m [N];
    for (int a = 0; a < N; a++) m[a] = '0;
    exp_fail = 1'b0; exp_fail_addr = 0; exp_fail_elem = 0; exp_cnt = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        int a = (e == 3 || e == 4) ? N - 1 - i : i;
        if (e != 0) begin
          logic [DW-1:0] rv = (e == 2 || e == 4) ? 8'hFF : 8'h00;
          if (m[a] != rv) begin
            if (!exp_fail) begin exp_fail_addr = a; exp_fail_elem = e; end
            exp_fail = 1'b1;
            exp_cnt++;
          end
        end
        if (e != 5) begin
          logic [DW-1:0] wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
          m[a] = (wv | sa1[a]) & ~sa0[a];
        end
      end
    end
  endtask

  // Per-cycle compare against the expected run profile
  logic chk_en = 1'b0;
  logic restart_hold = 1'b0;
  int   cyc = 0;
  int   men_cnt = 0;
  int   busy_cnt = 0;
  int   runs_done = 0;
  int   obs_addr [OPS];
  logic [DW-1:0] obs_din [OPS];

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc == 0) begin men_cnt = 0; busy_cnt = 0; end
      if (bus.A_BIST_MEN) men_cnt++;
      if (bus.A_BUSY) busy_cnt++;
      if (cyc < OPS) begin
        chk("busy", bus.A_BUSY, 1);
        chk("bist_en", bus.A_BIST_EN, 1);
        chk("bm", bus.A_BIST_BM, 8'hFF);
        chk("men", bus.A_BIST_MEN, 1);
        chk("ren", bus.A_BIST_REN, exp_rd[cyc]);
        chk("wen", bus.A_BIST_WEN, !exp_rd[cyc]);
        chk("addr", bus.A_BIST_ADDR, exp_addr[cyc]);
        if (!exp_rd[cyc]) chk("din", bus.A_BIST_DIN, exp_din[cyc]);
        if (cyc <= N + 1) begin
          chk("done_clr", bus.A_DONE, 0);
          chk("fail_clr", bus.A_FAIL, 0);
        end
        obs_addr[cyc] = int'(bus.A_BIST_ADDR);
        obs_din[cyc]  = bus.A_BIST_DIN;
        cyc++;
      end else if (cyc == OPS) begin
        chk("drain_busy", bus.A_BUSY, 1);
        chk("drain_en", bus.A_BIST_EN, 1);
        chk("drain_men", bus.A_BIST_MEN, 0);
        chk("drain_done", bus.A_DONE, 0);
        cyc++;
      end else begin
        chk("done_busy", bus.A_BUSY, 0);
        chk("done", bus.A_DONE, 1);
        chk("done_en", bus.A_BIST_EN, 0);
        chk("done_bm", bus.A_BIST_BM, 0);
        chk("busy_cycles", busy_cnt, OPS + 1);
        chk("men_cycles", men_cnt, OPS);
        chk("fail", bus.A_FAIL, exp_fail);
        if (exp_fail) begin
          chk("fail_addr", bus.A_FAIL_ADDR, exp_fail_addr);
          chk("fail_elem", bus.A_FAIL_ELEM, exp_fail_elem);
        end
`ifdef SRAM_MARCH_BIST_FAIL_CNT_EN
        chk("fail_cnt", bus.A_FAIL_CNT, exp_cnt);
`endif
        runs_done++;
        if (restart_hold) cyc = 0;
        else chk_en = 1'b0;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_en"}, bus.A_BIST_EN, 0);
    chk({tag, "_addr"}, bus.A_BIST_ADDR, 0);
    chk({tag, "_din"}, bus.A_BIST_DIN, 0);
    chk({tag, "_bm"}, bus.A_BIST_BM, 0);
    chk({tag, "_men"}, bus.A_BIST_MEN, 0);
    chk({tag, "_wen"}, bus.A_BIST_WEN, 0);
    chk({tag, "_ren"}, bus.A_BIST_REN, 0);
    chk({tag, "_busy"}, bus.A_BUSY, 0);
    chk({tag, "_done"}, bus.A_DONE, 0);
    chk({tag, "_fail"}, bus.A_FAIL, 0);
    chk({tag, "_faddr"}, bus.A_FAIL_ADDR, 0);
    chk({tag, "_felem"}, bus.A_FAIL_ELEM, 0);
`ifdef SRAM_MARCH_BIST_FAIL_CNT_EN
    chk({tag, "_fcnt"}, bus.A_FAIL_CNT, 0);
`endif
  endtask

  task automatic clear_faults();
    for (int a = 0; a < N; a++) begin sa1[a] = '0; sa0[a] = '0; end
  endtask

  task automatic start_run(input logic hold);
    @(posedge clk); #1;
    bus.A_START  = 1'b1;
    restart_hold = hold;
    @(posedge clk); #1;
    if (!hold) bus.A_START = 1'b0;
    cyc     = 0;
    chk_en  = 1'b1;
  endtask

  task automatic wait_runs(input int target);
    int t = 0;
    while (runs_done < target && t < 400) begin
      @(negedge clk); #1;
      t++;
    end
    chk("run_timeout", runs_done >= target, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e3_addr [8];
    e3_addr = '{3, 3, 2, 2, 1, 1, 0, 0};
    rst_n = 1'b0;
    bus.A_START = 1'b0;
    bus.A_BIST_DOUT = '0;
    for (int a = 0; a < N; a++) mem[a] = '0;
    clear_faults();
    build_ops();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;

    // Fault-free run plus sequence trace
    model_march();
    start_run(1'b0);
    wait_runs(1);
    chk("t1_fail", bus.A_FAIL, 0);
    chk("t1_done", bus.A_DONE, 1);
    for (int i = 0; i < 8; i++) chk("e3_addr", obs_addr[20 + i], e3_addr[i]);
    chk("din_e0", obs_din[0], 8'h00);
    chk("din_e1", obs_din[5], 8'hFF);
    chk("din_e2", obs_din[13], 8'h00);
    chk("din_e3", obs_din[21], 8'hFF);
    chk("din_e4", obs_din[29], 8'h00);

    // Address 2 bit 3 stuck-at-1
    sa1[2] = 8'h08;
    model_march();
    start_run(1'b0);
    wait_runs(2);
    chk("t2_fail", bus.A_FAIL, 1);
    chk("t2_faddr", bus.A_FAIL_ADDR, 2);
    chk("t2_felem", bus.A_FAIL_ELEM, 1);
`ifdef SRAM_MARCH_BIST_FAIL_CNT_EN
    chk("t2_fcnt", bus.A_FAIL_CNT, 3);
`endif

    // Address 3 bit 0 stuck-at-0
    clear_faults();
    sa0[3] = 8'h01;
    model_march();
    start_run(1'b0);
    wait_runs(3);
    chk("t3_fail", bus.A_FAIL, 1);
    chk("t3_faddr", bus.A_FAIL_ADDR, 3);
    chk("t3_felem", bus.A_FAIL_ELEM, 2);

    // Reset during cycle 15 of a run, then a full run
    clear_faults();
    model_march();
    start_run(1'b0);
    repeat (16) @(negedge clk);
    #1;
    rst_n  = 1'b0;
    chk_en = 1'b0;
    @(posedge clk); #1;
    check_zero("midrst");
    rst_n = 1'b1;
    start_run(1'b0);
    wait_runs(4);
    chk("t4_done", bus.A_DONE, 1);

    // Start held high: no restart while busy, restart from DONE
    sa1[2] = 8'h08;
    model_march();
    start_run(1'b1);
    wait_runs(5);
    restart_hold = 1'b0;
    wait_runs(6);
    bus.A_START = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_done_hold", bus.A_DONE, 1);
    chk("t5_busy_hold", bus.A_BUSY, 0);
    chk("t5_fail_hold", bus.A_FAIL, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_march_bist_ctrl.md
Name: sram_march_bist_ctrl

Overview:
- March C- BIST controller that drives the BIST-side port group of a single-port SRAM macro (BIST enable, address, data-in, bit mask, MEN/WEN/REN) and checks the macro's registered DOUT.
- Sits directly upstream of the SRAM instance; on completion it reports pass/fail plus first-failure diagnostics.
- The macro's BIST clock input is tied to A_CLK at the integration level; this block does not generate a clock.

Parameters:
- P_DATA_WIDTH, 64, SRAM word width.
- P_ADDR_WIDTH, 6, SRAM address width; depth N = 2**P_ADDR_WIDTH.

Ports:
- A_CLK, in, 1: single clock. Rising edge; the SRAM BIST clock is the same net.
- A_RST_N, in, 1: reset. Synchronous, active-low.
- A_START, in, 1: start-test pulse; sampled only in IDLE or DONE.
- A_BIST_EN, out, 1: selects the BIST port group at the SRAM.
- A_BIST_ADDR, out, P_ADDR_WIDTH: SRAM address.
- A_BIST_DIN, out, P_DATA_WIDTH: write data; all-0 or all-1 background.
- A_BIST_BM, out, P_DATA_WIDTH: bit mask; all ones whenever A_BIST_EN=1, else 0.
- A_BIST_MEN, out, 1: memory enable.
- A_BIST_WEN, out, 1: write enable.
- A_BIST_REN, out, 1: read enable.
- A_BIST_DOUT, in, P_DATA_WIDTH: SRAM DOUT, valid the cycle after a read is issued.
- A_BUSY, out, 1: test in progress.
- A_DONE, out, 1: test finished; held until the next start or reset.
- A_FAIL, out, 1: sticky mismatch flag.
- A_FAIL_ADDR, out, P_ADDR_WIDTH: address of the first mismatch.
- A_FAIL_ELEM, out, 3: march element index (0-5) of the first mismatch.

Behaviour:
- Reset: all outputs 0 and state IDLE. Reset mid-test aborts immediately: A_BIST_EN drops on the next cycle and SRAM contents are left undefined.

March elements (order and address direction):
- E0 up(w0), E1 up(r0,w1), E2 up(r1,w0), E3 down(r0,w1), E4 down(r1,w0), E5 up(r0).
- "up" runs addresses 0..N-1; "down" runs N-1..0.

Operation timing:
- One SRAM operation per cycle; no idle cycles between operations or elements.
- Read op: MEN=1, REN=1, WEN=0.
- Write op: MEN=1, WEN=1, REN=0, DIN = background.
- Read-write elements issue the read then the write at the same address on consecutive cycles, then advance the address.
- Total of 10N operation cycles.

FSM:
- IDLE: A_START=1 -> RUN at E0, address 0. A_BUSY=1 and A_BIST_EN=1 from the next cycle. A_DONE and fail fields are cleared on that same edge.
- RUN: after the last operation of E5 (address N-1) -> DRAIN.
- DRAIN: one cycle; A_BIST_EN=1, MEN=0; the final read compare completes. Then -> DONE.
- DONE: A_BUSY=0, A_DONE=1, A_BIST_EN=0. A_START=1 -> restart exactly as from IDLE.
- A_START is ignored while in RUN or DRAIN.
- A_BUSY is high for exactly 10N+1 cycles.

Compare pipeline:
- When a read is issued, the expected word and the element/address are registered.
- On the next cycle they are compared against A_BIST_DOUT.
- On mismatch: A_FAIL is set. If this is the first failure, A_FAIL_ADDR and A_FAIL_ELEM are captured; later mismatches do not overwrite them.

Address counter:
- Up-counter wraps N-1 -> 0 at element boundaries; down-counter starts at N-1.
- N = 2 (P_ADDR_WIDTH=1) is legal.

Optional Feature:
- Macro: SRAM_MARCH_BIST_FAIL_CNT_EN.
- When defined: adds output A_FAIL_CNT (16 bits). It counts every mismatching read compare, saturates at 16'hFFFF, resets to 0, and clears on test start.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
1. Fault-free behavioural SRAM model, P_ADDR_WIDTH=2, P_DATA_WIDTH=8; pulse A_START -> A_BUSY high for 41 cycles, then A_DONE=1, A_FAIL=0; exactly 40 MEN cycles observed; BM=8'hFF throughout.
2. Same model with bit 3 of address 2 stuck-at-1 -> A_FAIL=1, A_FAIL_ADDR=2, A_FAIL_ELEM=1; with the feature enabled, A_FAIL_CNT=3 (E1, E3 and E5 reads fail).
3. Address 3 bit 0 stuck-at-0 -> first failure in E2: A_FAIL_ELEM=2, A_FAIL_ADDR=3.
4. A_RST_N=0 at cycle 15 of a run -> next cycle all outputs 0, A_BIST_EN=0; a new A_START then completes a full 41-cycle run.
5. A_START held high throughout a run -> no restart while busy; on reaching DONE it restarts, clearing A_DONE and A_FAIL.
6. Sequence trace -> E3 addresses issued in the order 3,3,2,2,1,1,0,0 (read/write pairs); DIN=8'hFF on E1/E3 writes and 8'h00 on E0/E2/E4 writes.
